// File: rtl/aes_load_ctrl.sv
// Load/launch controller between an SPI front end and an AES core: synchronizes
// chip enable, captures key/message/dir, starts the core and watches for completion.
module aes_load_ctrl #(
  parameter int K       = 192,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce_async,
  input  logic [K-1:0] key_a,
  input  logic [127:0] message_a,
  input  logic         dir_a,
  output logic         core_load,
  output logic [K-1:0] key,
  output logic [127:0] message,
  output logic         dir,
  input  logic         core_done,
  input  logic [127:0] core_result,
  output logic         done,
  output logic [127:0] translated,
  output logic         busy,
  output logic         overrun,
  output logic         timeout_err
);

  localparam int SYNC_STAGES = 2;
  // Counter holds the number of RUN cycles already completed; the cycle that sees
  // CNT_LAST is the TIMEOUT-th one and the last chance for core_done.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CAPTURE,
    S_RUN,
    S_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   ce_s;

  state_t       state_reg;
  logic [7:0]   cnt_reg;
  logic [K-1:0] key_reg;
  logic [127:0] message_reg;
  logic         dir_reg;
  logic [127:0] translated_reg;
  logic         core_load_reg;
  logic         done_reg;
  logic         busy_reg;
  logic         overrun_reg;
  logic         timeout_err_reg;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset) sync_reg[gi] <= 1'b0;
          else       sync_reg[gi] <= ce_async;
        end
      end else begin : g_chain
        always_ff @(posedge clk) begin
          if (reset) sync_reg[gi] <= 1'b0;
          else       sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign ce_s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      cnt_reg         <= '0;
      key_reg         <= '0;
      message_reg     <= '0;
      dir_reg         <= 1'b0;
      translated_reg  <= '0;
      core_load_reg   <= 1'b1;
      done_reg        <= 1'b0;
      busy_reg        <= 1'b0;
      overrun_reg     <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (ce_s) begin
            state_reg       <= S_LOAD;
            overrun_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
          end
        end
        S_LOAD: begin
          if (!ce_s) begin
            state_reg <= S_CAPTURE;
            busy_reg  <= 1'b1;
          end
        end
        S_CAPTURE: begin
          // SPI is idle here, so the sclk-domain buses are stable and safe to sample.
          key_reg       <= key_a;
          message_reg   <= message_a;
          dir_reg       <= dir_a;
          cnt_reg       <= '0;
          core_load_reg <= 1'b0;
          state_reg     <= S_RUN;
        end
        S_RUN: begin
          if (ce_s) overrun_reg <= 1'b1;
          if (core_done) begin
            translated_reg <= core_result;
            done_reg       <= 1'b1;
            core_load_reg  <= 1'b1;
            busy_reg       <= 1'b0;
            state_reg      <= S_DONE;
          end else if (cnt_reg == CNT_LAST) begin
            timeout_err_reg <= 1'b1;
            core_load_reg   <= 1'b1;
            busy_reg        <= 1'b0;
            state_reg       <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        S_DONE: begin
          if (ce_s) begin
            done_reg        <= 1'b0;
            overrun_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
            state_reg       <= S_LOAD;
          end
        end
        default: begin
          state_reg     <= S_IDLE;
          core_load_reg <= 1'b1;
          done_reg      <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign core_load   = core_load_reg;
  assign key         = key_reg;
  assign message     = message_reg;
  assign dir         = dir_reg;
  assign done        = done_reg;
  assign translated  = translated_reg;
  assign busy        = busy_reg;
  assign overrun     = overrun_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_aes_load_ctrl.sv
// Scoreboard bench for aes_load_ctrl: directed operations push expected results,
// a negedge monitor pops them whenever done or timeout_err rises.
module tb_aes_load_ctrl;
  localparam int K       = 192;
  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ce_async = 1'b0;
  logic [K-1:0] key_a = '0;
  logic [127:0] message_a = '0;
  logic         dir_a = 1'b0;
  logic         core_done = 1'b0;
  logic [127:0] core_result = '0;
  logic         core_load;
  logic [K-1:0] key;
  logic [127:0] message;
  logic         dir;
  logic         done;
  logic [127:0] translated;
  logic         busy;
  logic         overrun;
  logic         timeout_err;

  aes_load_ctrl #(.K(K), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ce_async(ce_async),
    .key_a(key_a), .message_a(message_a), .dir_a(dir_a),
    .core_load(core_load), .key(key), .message(message), .dir(dir),
    .core_done(core_done), .core_result(core_result),
    .done(done), .translated(translated), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         is_timeout;
    logic         ovr;
    logic [127:0] result;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  localparam logic [K-1:0]  KEY_A = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0]  MSG_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0]  RES_A = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [K-1:0]  KEY_B = 192'hfedcba9876543210f0e1d2c3b4a5968778695a4b3c2d1e0f;
  localparam logic [127:0]  MSG_B = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0]  RES_C = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [K-1:0]  KEY_D = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0]  MSG_D = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0]  RES_D = 128'hbd334f1d6e45f25ff712a214571fa5cc;
  localparam logic [127:0]  RES_E = 128'h974104846d0ad3ad7734ecb3ecee4eef;
  localparam logic [K-1:0]  KEY_F = 192'h111111111111111122222222222222223333333333333333;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor side of the scoreboard.
  task automatic sb_event(input logic is_to);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got %s event (translated=%h), required no event",
               is_to ? "timeout" : "done", translated);
      return;
    end
    e = sb_q.pop_front();
    txn++;
    check("sb_kind", 256'(is_to), 256'(e.is_timeout));
    check("sb_translated", 256'(translated), 256'(e.result));
    check("sb_overrun", 256'(overrun), 256'(e.ovr));
    check("sb_done", 256'(done), 256'(!e.is_timeout));
    $display("txn %0d: %s translated=%h overrun=%b", txn,
             is_to ? "timeout" : "done", translated, overrun);
  endtask

  logic done_q = 1'b0;
  logic to_q = 1'b0;
  always @(negedge clk) begin
    if (done && !done_q) sb_event(1'b0);
    if (timeout_err && !to_q) sb_event(1'b1);
    done_q = done;
    to_q   = timeout_err;
  end

  // Called just after ce_async falls while the FSM sits in LOAD.
  task automatic enter_run(input logic [K-1:0] old_k, input logic [K-1:0] ek,
                           input logic [127:0] em, input logic ed, input string tag);
    step(2);
    check({tag, "_busy_pre"}, 256'(busy), 256'(0));
    step(1);
    check({tag, "_busy_capture"}, 256'(busy), 256'(1));
    check({tag, "_load_capture"}, 256'(core_load), 256'(1));
    check({tag, "_key_held"}, 256'(key), 256'(old_k));
    step(1);
    check({tag, "_load_fall"}, 256'(core_load), 256'(0));
    check({tag, "_key"}, 256'(key), 256'(ek));
    check({tag, "_message"}, 256'(message), 256'(em));
    check({tag, "_dir"}, 256'(dir), 256'(ed));
  endtask

  initial begin
    step(3);
    check("rst_core_load", 256'(core_load), 256'(1));
    check("rst_done", 256'(done), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_overrun", 256'(overrun), 256'(0));
    check("rst_timeout", 256'(timeout_err), 256'(0));
    check("rst_key", 256'(key), 256'(0));
    check("rst_translated", 256'(translated), 256'(0));
    reset = 1'b0;

    // Operation A: reference vector, core_done 12 cycles after core_load falls.
    key_a = KEY_A; message_a = MSG_A; dir_a = 1'b0;
    ce_async = 1'b1;
    step(10);
    ce_async = 1'b0;
    enter_run('0, KEY_A, MSG_A, 1'b0, "A");
    step(12);
    check("A_done_pre", 256'(done), 256'(0));
    core_result = RES_A;
    core_done = 1'b1;
    sb_q.push_back('{is_timeout: 1'b0, ovr: 1'b0, result: RES_A});
    step(1);
    core_done = 1'b0;
    core_result = '0;
    check("A_done", 256'(done), 256'(1));
    check("A_translated", 256'(translated), 256'(RES_A));

    // ce rises again: done drops on the third edge, translated held.
    step(2);
    ce_async = 1'b1;
    step(2);
    check("A_done_hold", 256'(done), 256'(1));
    step(1);
    check("A_done_drop", 256'(done), 256'(0));
    check("A_translated_held", 256'(translated), 256'(RES_A));

    // Operation B: core never answers, watchdog fires after TIMEOUT RUN cycles.
    step(4);
    key_a = KEY_B; message_a = MSG_B; dir_a = 1'b1;
    ce_async = 1'b0;
    enter_run(KEY_A, KEY_B, MSG_B, 1'b1, "B");
    sb_q.push_back('{is_timeout: 1'b1, ovr: 1'b0, result: RES_A});
    step(TIMEOUT - 1);
    check("B_timeout_pre", 256'(timeout_err), 256'(0));
    check("B_load_pre", 256'(core_load), 256'(0));
    step(1);
    check("B_timeout", 256'(timeout_err), 256'(1));
    check("B_done", 256'(done), 256'(0));
    check("B_idle_load", 256'(core_load), 256'(1));
    check("B_idle_busy", 256'(busy), 256'(0));

    // Operation C: timeout_err clears on LOAD entry; core_done on the last RUN cycle wins.
    ce_async = 1'b1;
    step(2);
    check("C_timeout_sticky", 256'(timeout_err), 256'(1));
    step(1);
    check("C_timeout_clear", 256'(timeout_err), 256'(0));
    step(4);
    dir_a = 1'b0;
    ce_async = 1'b0;
    enter_run(KEY_B, KEY_B, MSG_B, 1'b0, "C");
    step(TIMEOUT - 1);
    core_result = RES_C;
    core_done = 1'b1;
    sb_q.push_back('{is_timeout: 1'b0, ovr: 1'b0, result: RES_C});
    step(1);
    core_done = 1'b0;
    check("C_done", 256'(done), 256'(1));
    check("C_no_timeout", 256'(timeout_err), 256'(0));

    // Operation D: ce pulse during RUN, DONE entered with ce still high.
    ce_async = 1'b1;
    step(3);
    check("D_done_drop", 256'(done), 256'(0));
    step(3);
    key_a = KEY_D; message_a = MSG_D; dir_a = 1'b1;
    ce_async = 1'b0;
    enter_run(KEY_B, KEY_D, MSG_D, 1'b1, "D");
    step(2);
    ce_async = 1'b1;
    step(2);
    check("D_overrun_pre", 256'(overrun), 256'(0));
    step(1);
    check("D_overrun_set", 256'(overrun), 256'(1));
    step(1);
    ce_async = 1'b0;
    core_result = RES_D;
    core_done = 1'b1;
    sb_q.push_back('{is_timeout: 1'b0, ovr: 1'b1, result: RES_D});
    step(1);
    core_done = 1'b0;
    check("D_done", 256'(done), 256'(1));
    check("D_overrun", 256'(overrun), 256'(1));
    step(1);
    check("D_load_done", 256'(done), 256'(0));
    check("D_load_overrun_clr", 256'(overrun), 256'(0));
    check("D_load_busy", 256'(busy), 256'(0));

    // Operation E: the trailing ce fall restarts a capture immediately.
    step(1);
    check("E_busy_capture", 256'(busy), 256'(1));
    step(1);
    check("E_load_fall", 256'(core_load), 256'(0));
    check("E_key", 256'(key), 256'(KEY_D));
    step(4);
    core_result = RES_E;
    core_done = 1'b1;
    sb_q.push_back('{is_timeout: 1'b0, ovr: 1'b0, result: RES_E});
    step(1);
    core_done = 1'b0;
    check("E_done", 256'(done), 256'(1));
    check("E_translated", 256'(translated), 256'(RES_E));

    // Operation F: reset 5 cycles into RUN aborts; a later core_done is ignored.
    ce_async = 1'b1;
    step(6);
    key_a = KEY_F;
    ce_async = 1'b0;
    enter_run(KEY_D, KEY_F, MSG_D, 1'b1, "F");
    step(5);
    reset = 1'b1;
    step(1);
    check("F_rst_core_load", 256'(core_load), 256'(1));
    check("F_rst_key", 256'(key), 256'(0));
    check("F_rst_message", 256'(message), 256'(0));
    check("F_rst_dir", 256'(dir), 256'(0));
    check("F_rst_done", 256'(done), 256'(0));
    check("F_rst_translated", 256'(translated), 256'(0));
    check("F_rst_busy", 256'(busy), 256'(0));
    check("F_rst_overrun", 256'(overrun), 256'(0));
    check("F_rst_timeout", 256'(timeout_err), 256'(0));
    reset = 1'b0;
    step(3);
    core_result = RES_A;
    core_done = 1'b1;
    step(1);
    core_done = 1'b0;
    step(2);
    check("F_done_ignored", 256'(done), 256'(0));
    check("F_translated_zero", 256'(translated), 256'(0));
    check("F_idle_load", 256'(core_load), 256'(1));

    step(5);
    check("sb_empty", 256'(sb_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_load_ctrl.md
AES_LOAD_CTRL -- requirements
Module: aes_load_ctrl

Interface
REQ-001 Parameter: K, 192, key width in bits (128, 192 or 256).
REQ-002 Parameter: TIMEOUT, 255, max clk cycles in RUN awaiting core_done.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 ce_async  input  1  raw chip enable from the SPI master, asynchronous to clk.
REQ-006 key_a  input  K  key from SPI shift register, sclk domain.
REQ-007 message_a  input  128  plaintext/ciphertext from SPI shift register, sclk domain.
REQ-008 dir_a  input  1  direction bit from SPI shift register, sclk domain.
REQ-009 core_load  output  1  load to AES core; high = hold/load, falling edge = start.
REQ-010 key  output  K  registered key to core.
REQ-011 message  output  128  registered message to core.
REQ-012 dir  output  1  registered direction bit to core.
REQ-013 core_done  input  1  completion flag from AES core, clk domain.
REQ-014 core_result  input  128  core output, valid while core_done high.
REQ-015 done  output  1  result ready for SPI shift-out.
REQ-016 translated  output  128  latched result.
REQ-017 busy  output  1  high in CAPTURE and RUN.
REQ-018 overrun  output  1  sticky: ce seen during RUN.
REQ-019 timeout_err  output  1  sticky: core did not finish within TIMEOUT cycles.

Function
REQ-020 ce_async synchronized by two flops to ce_s; no other use of ce_async.
REQ-021 key_a/message_a/dir_a sampled only in CAPTURE; SPI is quiescent then, so no synchronizer on them.
REQ-022 FSM states: IDLE, LOAD, CAPTURE, RUN, DONE.
REQ-023 IDLE: core_load=1, done=0; ce_s=1 -> LOAD.
REQ-024 LOAD: core_load=1, done=0; ce_s=0 -> CAPTURE.
REQ-025 CAPTURE: one cycle; key/message/dir <= *_a; core_load=1; -> RUN.
REQ-026 RUN: core_load=0; 8-bit cycle counter increments from 0 on entry.
REQ-027 RUN: core_done=1 -> DONE, translated <= core_result in the same edge.
REQ-028 RUN: counter reaches TIMEOUT with core_done=0 -> timeout_err<=1, -> IDLE, translated unchanged.
REQ-029 RUN: core_done and timeout in the same cycle -> core_done wins (DONE, no error).
REQ-030 RUN: ce_s=1 on any cycle -> overrun<=1; FSM still completes RUN.
REQ-031 DONE: done=1, core_load=1; ce_s=1 -> LOAD with done=0 on next cycle; translated held.
REQ-032 DONE entered with ce_s already high (overrun case) -> LOAD on following cycle.
REQ-033 Latency: ce_async fall -> CAPTURE at 3rd clk edge after the fall (2 sync + 1 transition); core_load falls one cycle later.
REQ-034 done rises on the edge after core_done first sampled high.
REQ-035 ce pulses shorter than one clk period may be missed; no requirement to detect them.
REQ-036 overrun and timeout_err clear only on reset or on entry to LOAD.
REQ-037 key/message/dir change only in CAPTURE.

Reset
REQ-038 While reset=1 at a clk edge: state=IDLE, sync flops=0, counter=0, key/message/dir=0, translated=0, done=0, busy=0, overrun=0, timeout_err=0; core_load=1.
REQ-039 reset in any state, including mid-RUN, aborts the operation; ignored core_done afterwards.

Verification
REQ-040 ce_async high 10 cycles then low, key_a=000102..17h (K=192), message_a=00112233445566778899aabbccddeeffh, core_done 12 cycles after core_load fall with result dda97ca4864cdfe06eaf70a0ec0d7191h -> key/message latched in CAPTURE, done=1 one cycle later, translated equals result.
REQ-041 Same as 040, then ce_async high again -> done drops 3 cycles after ce rise; translated unchanged.
REQ-042 core_done never asserted, TIMEOUT=16 -> after 16 RUN cycles timeout_err=1, state IDLE, done=0.
REQ-043 ce_async pulsed high for 4 cycles during RUN -> overrun=1, core_done still produces done=1, then LOAD next cycle.
REQ-044 reset asserted 5 cycles into RUN -> all outputs at reset values next cycle; later core_done pulse leaves done=0.
REQ-045 core_done rises on the exact cycle counter hits TIMEOUT -> done=1, timeout_err=0.
